// File: rtl/ysyx_220066_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Covers the FSM state encoding, trap kind and standard mcause values.
package ysyx_220066_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_RET  = 1'b1
    } kind_t;

    localparam logic [63:0] IRQ_CAUSE_MTI    = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;
    localparam logic [63:0] CAUSE_ILLEGAL    = 64'd2;
    localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;

    function automatic logic irq_pending(input logic mtip, input logic mie, input logic mtie);
        return mtip & mie & mtie;
    endfunction

endpackage

// File: rtl/ysyx_220066_trap_ctrl_if.sv
// Commit-side, CSR-side and fetch-side signals of the trap sequencer.
// The slave modport is the sequencer itself; master is the surrounding pipeline.
interface ysyx_220066_trap_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc;
    logic             exc_valid;
    logic [XLEN-1:0]  exc_code;
    logic             mret_req;
    logic             csr_wen_req;
    logic [XLEN-1:0]  next_pc;
    logic             pipe_empty;
    logic             timer_irq;
    logic             mstatus_mie;
    logic             mie_mtie;
    logic             redirect_ack;
    logic             csr_wen;
    logic             raise_intr;
    logic             ret;
    logic [XLEN-1:0]  NO;
    logic [XLEN-1:0]  epc;
    logic             flush;
    logic             stall_fetch;
    logic             busy;
    logic [CNT_W-1:0] trap_cnt;

    modport slave (
        input  commit_valid, commit_pc, exc_valid, exc_code, mret_req, csr_wen_req,
               next_pc, pipe_empty, timer_irq, mstatus_mie, mie_mtie, redirect_ack,
        output csr_wen, raise_intr, ret, NO, epc, flush, stall_fetch, busy, trap_cnt
    );

    modport master (
        output commit_valid, commit_pc, exc_valid, exc_code, mret_req, csr_wen_req,
               next_pc, pipe_empty, timer_irq, mstatus_mie, mie_mtie, redirect_ack,
        input  csr_wen, raise_intr, ret, NO, epc, flush, stall_fetch, busy, trap_cnt
    );
endinterface

// File: rtl/ysyx_220066_trap_ctrl.sv
// Trap sequencer: turns committed exceptions, mret and timer interrupts into
// one-cycle raise_intr/ret strobes, then holds flush until fetch redirects.
module ysyx_220066_trap_ctrl
    import ysyx_220066_trap_ctrl_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] IRQ_CAUSE = IRQ_CAUSE_MTI,
    parameter int          CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_220066_trap_ctrl_if.slave bus
);

    state_t           state_reg, state_next;
    kind_t            kind_reg, kind_next;
    logic [XLEN-1:0]  no_reg, no_next;
    logic [XLEN-1:0]  epc_reg, epc_next;
    logic             raise_reg, raise_next;
    logic             ret_reg, ret_next;
    logic [CNT_W-1:0] cnt_reg;

    logic irq_pend;
    logic take_exc;
    logic take_ret;
    logic accepting;

    assign irq_pend  = irq_pending(bus.timer_irq, bus.mstatus_mie, bus.mie_mtie);
    assign take_exc  = bus.commit_valid & bus.exc_valid;
    assign take_ret  = bus.commit_valid & bus.mret_req & ~bus.exc_valid;
    assign accepting = (state_reg == S_IDLE) || (state_reg == S_DRAIN);

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        no_next    = no_reg;
        epc_next   = epc_reg;

        case (state_reg)
            S_IDLE, S_DRAIN: begin
                // A retiring exception or mret always wins; a pending interrupt
                // is simply re-sampled later because mtip is level-sensitive.
                if (take_exc) begin
                    no_next    = bus.exc_code;
                    epc_next   = bus.commit_pc;
                    kind_next  = KIND_TRAP;
                    state_next = S_ISSUE;
                end else if (take_ret) begin
                    kind_next  = KIND_RET;
                    state_next = S_ISSUE;
                end else if (state_reg == S_IDLE) begin
                    if (irq_pend) state_next = S_DRAIN;
                end else if (!irq_pend) begin
                    state_next = S_IDLE;
                end else if (bus.pipe_empty) begin
                    no_next    = IRQ_CAUSE[XLEN-1:0];
                    epc_next   = bus.next_pc;
                    kind_next  = KIND_TRAP;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE:    state_next = S_WAIT_ACK;
            S_WAIT_ACK: if (bus.redirect_ack) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase

        raise_next = (state_next == S_ISSUE) && (kind_next == KIND_TRAP);
        ret_next   = (state_next == S_ISSUE) && (kind_next == KIND_RET);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            kind_reg  <= KIND_TRAP;
            no_reg    <= '0;
            epc_reg   <= '0;
            raise_reg <= 1'b0;
            ret_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            kind_reg  <= kind_next;
            no_reg    <= no_next;
            epc_reg   <= epc_next;
            raise_reg <= raise_next;
            ret_reg   <= ret_next;
            if (raise_reg) cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Strobes only exist in ISSUE, so csr_wen can never coincide with them.
    assign bus.csr_wen     = bus.csr_wen_req & bus.commit_valid & ~bus.exc_valid
                             & ~bus.mret_req & accepting;
    assign bus.raise_intr  = raise_reg;
    assign bus.ret         = ret_reg;
    assign bus.NO          = no_reg;
    assign bus.epc         = epc_reg;
    assign bus.flush       = (state_reg == S_ISSUE) || (state_reg == S_WAIT_ACK);
    assign bus.stall_fetch = (state_reg != S_IDLE);
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.trap_cnt    = cnt_reg;

endmodule

// File: tb/tb_ysyx_220066_trap_ctrl.sv
// Directed bench for the trap sequencer: exceptions, mret, drained timer
// interrupts, priority inside DRAIN, interrupt abandonment and async reset.
module tb_ysyx_220066_trap_ctrl;
    import ysyx_220066_trap_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ysyx_220066_trap_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();

    ysyx_220066_trap_ctrl #(
        .XLEN(64),
        .IRQ_CAUSE(64'h8000_0000_0000_0007),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = '0;
        bus.mret_req     = 1'b0;
        bus.csr_wen_req  = 1'b0;
        bus.redirect_ack = 1'b0;
    endtask

    // flags = {raise_intr, ret, flush, stall_fetch, busy}
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.next_pc = '0; bus.pipe_empty = 1'b1;
        bus.timer_irq = 1'b0; bus.mstatus_mie = 1'b1; bus.mie_mtie = 1'b1;
        tick(); tick();
        tests++;
        if ({bus.raise_intr, bus.ret, bus.flush, bus.stall_fetch, bus.busy} !== 5'b00000) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.raise_intr, bus.ret, bus.flush, bus.stall_fetch, bus.busy});
        end
        tests++;
        if ({bus.NO, bus.epc, bus.trap_cnt} !== 160'd0) begin
            fails++; $display("FAIL reset_regs: NO=%h epc=%h cnt=%0d expected all zero",
                bus.NO, bus.epc, bus.trap_cnt);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset: done");
    endtask

    task automatic test_exception();
        bus.commit_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = 64'd11;
        bus.commit_pc = 64'h8000_0010; bus.csr_wen_req = 1'b1;
        #1;
        tests++;
        if (bus.csr_wen !== 1'b0) begin
            fails++; $display("FAIL exc_csr_wen_gate: got %b expected 0", bus.csr_wen);
        end
        tick();
        clear_inputs();
        tests++;
        if ({bus.raise_intr, bus.ret, bus.flush, bus.stall_fetch, bus.busy} !== 5'b10111) begin
            fails++; $display("FAIL exc_issue_flags: got %b expected 10111",
                {bus.raise_intr, bus.ret, bus.flush, bus.stall_fetch, bus.busy});
        end
        tests++;
        if (bus.NO !== 64'd11 || bus.epc !== 64'h8000_0010) begin
            fails++; $display("FAIL exc_cause_epc: NO=%h epc=%h expected 000000000000000b/0000000080000010",
                bus.NO, bus.epc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({bus.raise_intr, bus.flush, bus.stall_fetch} !== 3'b011) begin
                fails++; $display("FAIL exc_wait_ack_hold%0d: got %b expected 011", i,
                    {bus.raise_intr, bus.flush, bus.stall_fetch});
            end
        end
        tests++;
        if (bus.trap_cnt !== 32'd1) begin
            fails++; $display("FAIL exc_trap_cnt: got %0d expected 1", bus.trap_cnt);
        end
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        tests++;
        if ({bus.flush, bus.stall_fetch, bus.busy} !== 3'b000) begin
            fails++; $display("FAIL exc_release: got %b expected 000",
                {bus.flush, bus.stall_fetch, bus.busy});
        end
        $display("[TB] exception: ecall NO=%h epc=%h cnt=%0d", bus.NO, bus.epc, bus.trap_cnt);
    endtask

    task automatic test_mret();
        bus.commit_valid = 1'b1; bus.mret_req = 1'b1; bus.csr_wen_req = 1'b1;
        #1;
        tests++;
        if (bus.csr_wen !== 1'b0) begin
            fails++; $display("FAIL mret_csr_wen_gate: got %b expected 0", bus.csr_wen);
        end
        tick();
        clear_inputs();
        bus.redirect_ack = 1'b1;   // ack during ISSUE must be ignored
        tests++;
        if ({bus.raise_intr, bus.ret, bus.flush, bus.csr_wen} !== 4'b0110) begin
            fails++; $display("FAIL mret_issue: got %b expected 0110",
                {bus.raise_intr, bus.ret, bus.flush, bus.csr_wen});
        end
        tick();
        tests++;
        if ({bus.ret, bus.flush, bus.busy} !== 3'b011) begin
            fails++; $display("FAIL mret_ack_in_issue_ignored: got %b expected 011",
                {bus.ret, bus.flush, bus.busy});
        end
        tick();
        bus.redirect_ack = 1'b0;
        tests++;
        if ({bus.busy, bus.flush, bus.trap_cnt} !== {2'b00, 32'd1}) begin
            fails++; $display("FAIL mret_release: busy=%b flush=%b cnt=%0d expected 0 0 1",
                bus.busy, bus.flush, bus.trap_cnt);
        end
        $display("[TB] mret: ret strobe, busy released, cnt=%0d", bus.trap_cnt);
    endtask

    task automatic test_irq_drain();
        bus.timer_irq = 1'b1; bus.pipe_empty = 1'b0; bus.next_pc = 64'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({bus.stall_fetch, bus.raise_intr, bus.flush} !== 3'b100) begin
                fails++; $display("FAIL irq_drain_cycle%0d: got %b expected 100", i,
                    {bus.stall_fetch, bus.raise_intr, bus.flush});
            end
        end
        bus.pipe_empty = 1'b1;
        tick();
        bus.timer_irq = 1'b0;
        tests++;
        if (bus.raise_intr !== 1'b1 || bus.NO !== 64'h8000_0000_0000_0007 || bus.epc !== 64'h8000_0100) begin
            fails++; $display("FAIL irq_issue: raise=%b NO=%h epc=%h expected 1 8000000000000007 0000000080000100",
                bus.raise_intr, bus.NO, bus.epc);
        end
        bus.redirect_ack = 1'b1;
        tick(); tick();
        bus.redirect_ack = 1'b0;
        tests++;
        if ({bus.busy, bus.trap_cnt} !== {1'b0, 32'd2}) begin
            fails++; $display("FAIL irq_done: busy=%b cnt=%0d expected 0 2", bus.busy, bus.trap_cnt);
        end
        $display("[TB] irq_drain: NO=8000000000000007 epc=80000100 cnt=%0d", bus.trap_cnt);
    endtask

    task automatic test_irq_exc_priority();
        bus.timer_irq = 1'b1; bus.pipe_empty = 1'b0;
        tick();
        bus.commit_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = 64'd2;
        bus.commit_pc = 64'h8000_0200;
        tick();
        clear_inputs();
        bus.timer_irq = 1'b0;
        tests++;
        if (bus.raise_intr !== 1'b1 || bus.NO !== 64'd2 || bus.epc !== 64'h8000_0200) begin
            fails++; $display("FAIL drain_exc_priority: raise=%b NO=%h epc=%h expected 1 2 80000200",
                bus.raise_intr, bus.NO, bus.epc);
        end
        bus.redirect_ack = 1'b1;
        tick(); tick();
        bus.redirect_ack = 1'b0;
        bus.pipe_empty = 1'b1;
        $display("[TB] drain_exc_priority: NO=%h", bus.NO);
    endtask

    task automatic test_irq_abandon();
        bus.timer_irq = 1'b1; bus.pipe_empty = 1'b0;
        tick();
        bus.commit_valid = 1'b1; bus.csr_wen_req = 1'b1; bus.mstatus_mie = 1'b0;
        #1;
        tests++;
        if ({bus.csr_wen, bus.stall_fetch} !== 2'b11) begin
            fails++; $display("FAIL abandon_csr_wen_in_drain: got %b expected 11",
                {bus.csr_wen, bus.stall_fetch});
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({bus.stall_fetch, bus.busy, bus.raise_intr, bus.ret, bus.trap_cnt} !== {4'b0000, 32'd3}) begin
                fails++; $display("FAIL abandon_idle%0d: stall=%b busy=%b raise=%b ret=%b cnt=%0d expected 0 0 0 0 3",
                    i, bus.stall_fetch, bus.busy, bus.raise_intr, bus.ret, bus.trap_cnt);
            end
            tick();
        end
        bus.timer_irq = 1'b0; bus.mstatus_mie = 1'b1; bus.pipe_empty = 1'b1;
        $display("[TB] irq_abandon: back to IDLE without strobe");
    endtask

    task automatic test_back_to_back();
        // exception + mret + interrupt together: exception wins
        bus.timer_irq = 1'b1;
        bus.commit_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = 64'd3;
        bus.commit_pc = 64'h8000_0300; bus.mret_req = 1'b1;
        tick();
        clear_inputs();
        tests++;
        if ({bus.raise_intr, bus.ret} !== 2'b10 || bus.NO !== 64'd3) begin
            fails++; $display("FAIL prio_exc_over_mret: raise=%b ret=%b NO=%h expected 1 0 3",
                bus.raise_intr, bus.ret, bus.NO);
        end
        bus.redirect_ack = 1'b1;
        tick(); tick();
        // mret + interrupt together: mret wins
        bus.redirect_ack = 1'b0;
        bus.commit_valid = 1'b1; bus.mret_req = 1'b1;
        tick();
        clear_inputs();
        bus.timer_irq = 1'b0;
        tests++;
        if ({bus.raise_intr, bus.ret} !== 2'b01 || bus.NO !== 64'd3) begin
            fails++; $display("FAIL prio_mret_over_irq: raise=%b ret=%b NO=%h expected 0 1 3",
                bus.raise_intr, bus.ret, bus.NO);
        end
        tick();
        $display("[TB] back_to_back: priority checks done, cnt=%0d", bus.trap_cnt);
    endtask

    task automatic test_reset_wait_ack();
        tests++;
        if ({bus.flush, bus.busy, bus.trap_cnt} !== {2'b11, 32'd4}) begin
            fails++; $display("FAIL pre_reset_wait_ack: flush=%b busy=%b cnt=%0d expected 1 1 4",
                bus.flush, bus.busy, bus.trap_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.flush, bus.stall_fetch, bus.busy, bus.ret, bus.trap_cnt} !== {4'b0000, 32'd0}) begin
            fails++; $display("FAIL async_reset: flush=%b stall=%b busy=%b ret=%b cnt=%0d expected 0 0 0 0 0",
                bus.flush, bus.stall_fetch, bus.busy, bus.ret, bus.trap_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset_wait_ack: outputs cleared asynchronously");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_exception();
        test_mret();
        test_irq_drain();
        test_irq_exc_priority();
        test_irq_abandon();
        test_back_to_back();
        test_reset_wait_ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
